sd_cmd_arb: RTL and testbench

SD_CMD_ARB -- requirements
Module: sd_cmd_arb

---
 rtl/sd_pkg.sv | 22 ++
 rtl/sd_r1_rx.sv | 55 +++++
 rtl/sd_cmd_arb.sv | 192 +++++++++++++++++++
 tb/tb_sd_cmd_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD SPI definitions: FSM encoding, frame/R1 widths, timeout byte
// and a saturating counter helper.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_GAP
    } state_e;

    localparam int FRAME_W = 48;
    localparam int R1_W    = 8;

    localparam logic [R1_W-1:0] R1_TIMEOUT = 8'hFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sd_r1_rx.sv
// R1 receiver: hunts for the start bit (MISO low) while enabled, then
// shifts in the remaining bits MSB first and flags the final bit.
module sd_r1_rx
    import sd_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            miso_i,
    output logic            start_o,
    output logic            done_o,
    output logic [R1_W-1:0] byte_o
);

    logic            active_q, active_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [R1_W-2:0] shift_q, shift_d;

    assign start_o = en_i && !active_q && !miso_i;
    assign done_o  = en_i && active_q && (cnt_q == 3'(R1_W - 1));
    // Byte is complete combinationally during the cycle the last bit is sampled.
    assign byte_o  = {shift_q, miso_i};

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        if (!en_i || done_o) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start_o) begin
            active_d = 1'b1;
            cnt_d    = 3'd1;
            shift_d  = byte_o[R1_W-2:0];
        end else if (active_q) begin
            cnt_d    = cnt_q + 3'd1;
            shift_d  = byte_o[R1_W-2:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

endmodule

// File: rtl/sd_cmd_arb.sv
// Two-requester round-robin SD SPI command arbiter: sends a 48-bit frame,
// collects the R1 byte or times out. Optional stats via SD_CMD_ARB_STATS_EN.
module sd_cmd_arb
    import sd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 127,
    parameter int GAP_CYCLES   = 8
) (
    input  logic               SD_CK,
    input  logic               rst_n,
    input  logic               init_o,
    input  logic               req0_valid,
    input  logic [FRAME_W-1:0] req0_cmd,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [FRAME_W-1:0] req1_cmd,
    output logic               req1_ready,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [R1_W-1:0]    rsp_r1,
    output logic               rsp_timeout,
    output logic               busy,
    input  logic               SD_MISO,
    output logic               SD_MOSI,
    output logic               SD_CSn
`ifdef SD_CMD_ARB_STATS_EN
    ,
    output logic [15:0]        stat_cmd0,
    output logic [15:0]        stat_cmd1,
    output logic [15:0]        stat_tmo
`endif
);

    localparam int CNT_MAX0 = (RESP_TIMEOUT > FRAME_W - 1) ? RESP_TIMEOUT : FRAME_W - 1;
    localparam int CNT_MAX  = (GAP_CYCLES - 1 > CNT_MAX0) ? GAP_CYCLES - 1 : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] cmd_q, cmd_d;
    logic               id_q, last_q;
    logic               ready0_q, ready1_q;
    logic               rsp_valid_q, rsp_id_q, rsp_tmo_q;
    logic [R1_W-1:0]    rsp_r1_q;

    logic               grant, gnt_id;
    logic               rx_en, rx_start, rx_done;
    logic [R1_W-1:0]    rx_byte;
    logic               tmo_evt, rsp_evt;

    assign grant   = (state_q == ST_IDLE) && init_o && (req0_valid || req1_valid);
    // On contention the requester not served last wins.
    assign gnt_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign rx_en   = (state_q == ST_WAIT) || (state_q == ST_RECV);
    assign tmo_evt = (state_q == ST_WAIT) && !rx_start && (cnt_q == CNT_W'(1));
    assign rsp_evt = tmo_evt || ((state_q == ST_RECV) && rx_done);

    sd_r1_rx u_r1_rx (
        .clk_i   (SD_CK),
        .rst_ni  (rst_n),
        .en_i    (rx_en),
        .miso_i  (SD_MISO),
        .start_o (rx_start),
        .done_o  (rx_done),
        .byte_o  (rx_byte)
    );

    always_ff @(posedge SD_CK or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_SEND;
                    cnt_d   = CNT_W'(FRAME_W - 1);
                    cmd_d   = gnt_id ? req1_cmd : req0_cmd;
                end
            end
            ST_SEND: begin
                cmd_d = {cmd_q[FRAME_W-2:0], 1'b1};
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RESP_TIMEOUT);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (rx_start) begin
                    state_d = ST_RECV;
                    cnt_d   = '0;
                end else if (tmo_evt) begin
                    state_d = ST_GAP;
                end
            end
            ST_RECV: begin
                if (rx_done) state_d = ST_GAP;
            end
            ST_GAP: begin
                // Counter arrives here at zero from either WAIT or RECV.
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        SD_CSn  = 1'b1;
        SD_MOSI = 1'b1;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_SEND: begin
                SD_CSn  = 1'b0;
                SD_MOSI = cmd_q[FRAME_W-1];
            end
            ST_WAIT, ST_RECV: SD_CSn = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_r1_q    <= R1_TIMEOUT;
        end else begin
            cnt_q       <= cnt_d;
            ready0_q    <= grant && !gnt_id;
            ready1_q    <= grant && gnt_id;
            rsp_valid_q <= rsp_evt;
            if (grant) begin
                id_q   <= gnt_id;
                last_q <= gnt_id;
            end
            if (rsp_evt) begin
                rsp_id_q  <= id_q;
                rsp_tmo_q <= tmo_evt;
                rsp_r1_q  <= tmo_evt ? R1_TIMEOUT : rx_byte;
            end
        end
    end

    always_ff @(posedge SD_CK) begin
        cmd_q <= cmd_d;
    end

    assign req0_ready  = ready0_q;
    assign req1_ready  = ready1_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_r1      = rsp_r1_q;
    assign rsp_timeout = rsp_tmo_q;

`ifdef SD_CMD_ARB_STATS_EN
    logic [15:0] st_cmd0_q, st_cmd1_q, st_tmo_q;

    always_ff @(posedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            st_cmd0_q <= '0;
            st_cmd1_q <= '0;
            st_tmo_q  <= '0;
        end else if (rsp_evt) begin
            if (id_q) st_cmd1_q <= sat_inc16(st_cmd1_q);
            else      st_cmd0_q <= sat_inc16(st_cmd0_q);
            if (tmo_evt) st_tmo_q <= sat_inc16(st_tmo_q);
        end
    end

    assign stat_cmd0 = st_cmd0_q;
    assign stat_cmd1 = st_cmd1_q;
    assign stat_tmo  = st_tmo_q;
`endif

endmodule

// File: tb/tb_sd_cmd_arb.sv
// Scoreboard bench for sd_cmd_arb with a behavioural SPI card model.
module tb_sd_cmd_arb;

    localparam int TMO = 127;
    localparam int GAP = 8;

    typedef struct { int dly; logic [7:0] b; } card_t;
    typedef struct { logic id; logic [7:0] r1; logic tmo; int lat; } exp_t;

    logic        SD_CK = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_o = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [47:0] req0_cmd = '0, req1_cmd = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_timeout, busy;
    logic [7:0]  rsp_r1;
    logic        SD_MISO = 1'b1;
    logic        SD_MOSI, SD_CSn;
`ifdef SD_CMD_ARB_STATS_EN
    logic [15:0] stat_cmd0, stat_cmd1, stat_tmo;
`endif

    sd_cmd_arb #(.RESP_TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
        .SD_CK       (SD_CK),
        .rst_n       (rst_n),
        .init_o      (init_o),
        .req0_valid  (req0_valid),
        .req0_cmd    (req0_cmd),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_cmd    (req1_cmd),
        .req1_ready  (req1_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_r1      (rsp_r1),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .SD_MISO     (SD_MISO),
        .SD_MOSI     (SD_MOSI),
        .SD_CSn      (SD_CSn)
`ifdef SD_CMD_ARB_STATS_EN
        ,
        .stat_cmd0   (stat_cmd0),
        .stat_cmd1   (stat_cmd1),
        .stat_tmo    (stat_tmo)
`endif
    );

    always #5 SD_CK = ~SD_CK;

    int    n_tot = 0, n_bad = 0;
    int    cyc = 0, idx = 0, hi_cnt = 0, wait_cyc = 0, gap_arm = 0, ready_cnt = 0;
    logic  gnt_q[$];
    logic [47:0] frame_q[$];
    card_t card_q[$];
    exp_t  exp_q[$];
    card_t cur;
    logic [47:0] cur_frame, cap;
    logic [7:0]  last_r1 = 8'hFF;
    logic        last_id = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge SD_CK) cyc++;

    // Card model: records MOSI during the frame, answers after a programmed delay.
    always @(negedge SD_CK) begin
        if (SD_CSn) begin
            idx = 0;
            SD_MISO = 1'b1;
            hi_cnt++;
        end else begin
            if (idx == 0) begin
                if (card_q.size() > 0 && frame_q.size() > 0) begin
                    cur = card_q.pop_front();
                    cur_frame = frame_q.pop_front();
                end else begin
                    chk("frame_spurious", card_q.size(), 1);
                    cur.dly = -1;
                end
                if (gap_arm == 2) chk("gap_len", hi_cnt, GAP + 1);
                if (gap_arm == 1) gap_arm = 2;
                hi_cnt = 0;
            end
            if (idx < 48) cap[47-idx] = SD_MOSI;
            if (idx == 47) chk("mosi_frame", cap, cur_frame);
            if (idx == 48) wait_cyc = cyc;
            if (idx >= 48 && cur.dly >= 0 && idx - 48 >= cur.dly && idx - 48 < cur.dly + 8)
                SD_MISO = cur.b[7 - (idx - 48 - cur.dly)];
            else
                SD_MISO = 1'b1;
            idx++;
        end
    end

    always @(negedge SD_CK) begin
        if (req0_ready || req1_ready) begin
            ready_cnt++;
            chk("ready_both", req0_ready & req1_ready, 0);
            if (gnt_q.size() == 0) chk("ready_spurious", gnt_q.size(), 1);
            else chk("grant_id", req1_ready, gnt_q.pop_front());
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_r1", rsp_r1, e.r1);
                chk("rsp_timeout", rsp_timeout, e.tmo);
                chk("rsp_latency", cyc - wait_cyc, e.lat);
                last_r1 = e.r1;
                last_id = e.id;
            end
        end
    end

    task automatic push_txn(input logic id, input logic [47:0] cmd, input int dly,
                            input logic [7:0] b, input bit want_rsp);
        card_t c;
        exp_t  e;
        c.dly = dly;
        c.b   = b;
        gnt_q.push_back(id);
        frame_q.push_back(cmd);
        card_q.push_back(c);
        if (want_rsp) begin
            e.id  = id;
            e.tmo = (dly < 0);
            e.r1  = (dly < 0) ? 8'hFF : b;
            e.lat = (dly < 0) ? TMO : dly + 8;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic id, input logic [47:0] cmd, input int dly,
                        input logic [7:0] b, input bit want_rsp);
        logic got;
        push_txn(id, cmd, dly, b, want_rsp);
        if (id) begin req1_cmd = cmd; req1_valid = 1'b1; end
        else    begin req0_cmd = cmd; req0_valid = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge SD_CK);
            #1;
            got = id ? req1_ready : req0_ready;
        end
        chk("grant_wait", got, 1);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) begin
            @(posedge SD_CK);
            #1;
        end
        chk("drain", exp_q.size(), 0);
        chk("busy_end", busy, 0);
        chk("r1_hold", rsp_r1, last_r1);
        chk("id_hold", rsp_id, last_id);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge SD_CK);
        #3 rst_n = 1'b1;
        @(posedge SD_CK);
        #1;
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_csn", SD_CSn, 1);
        chk("rst_mosi", SD_MOSI, 1);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_r1", rsp_r1, 8'hFF);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_tmo", rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        #5 rst_n = 1'b1;
        @(posedge SD_CK);
        #1;

        // V1: basic command with R1 = 01 after 3 idle cycles
        send(1'b0, 48'h40_00_00_00_00_95, 3, 8'h01, 1'b1);
        wait_idle();

        // V3: card never answers
        send(1'b0, 48'h77_00_00_00_00_65, -1, 8'hFF, 1'b1);
        wait_idle();

        // V4: grants blocked by init_o; dropped request gives no response
        init_o = 1'b0;
        req0_cmd = 48'h51_00_00_00_00_FF;
        req0_valid = 1'b1;
        repeat (5) @(posedge SD_CK);
        #1 req0_valid = 1'b0;
        req1_cmd = 48'h49_12_34_56_78_9B;
        req1_valid = 1'b1;
        n = ready_cnt;
        repeat (100) @(posedge SD_CK);
        #1;
        chk("v4_no_ready", ready_cnt, n);
        push_txn(1'b1, 48'h49_12_34_56_78_9B, 0, 8'h05, 1'b1);
        init_o = 1'b1;
        @(posedge SD_CK);
        #1;
        chk("v4_ready_next", req1_ready, 1);
        req1_valid = 1'b0;
        repeat (10) @(posedge SD_CK);
        #1 init_o = 1'b0;
        wait_idle();
        init_o = 1'b1;

        // V2: both requesters held valid, round-robin from reset
        do_reset();
        push_txn(1'b0, 48'h4A_AA_00_00_00_01, 0, 8'h00, 1'b1);
        push_txn(1'b1, 48'h55_00_BB_00_00_03, 1, 8'h7E, 1'b1);
        push_txn(1'b0, 48'h4A_AA_00_00_00_01, 2, 8'h04, 1'b1);
        push_txn(1'b1, 48'h55_00_BB_00_00_03, 5, 8'h09, 1'b1);
        gap_arm = 1;
        req0_cmd = 48'h4A_AA_00_00_00_01;
        req1_cmd = 48'h55_00_BB_00_00_03;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 4000 && n < 4; i++) begin
            @(posedge SD_CK);
            #1;
            if (req0_ready || req1_ready) n++;
        end
        chk("v2_grants", n, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        gap_arm = 0;

        // V5: reset during SEND bit 20
        send(1'b0, 48'h5A_5A_5A_5A_5A_5A, 1, 8'h01, 1'b0);
        for (int i = 0; i < 100 && idx < 20; i++) @(posedge SD_CK);
        chk("v5_reached_bit20", idx, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("v5_csn_async", SD_CSn, 1);
        chk("v5_busy", busy, 0);
        chk("v5_rsp_valid", rsp_valid, 0);
        repeat (3) @(posedge SD_CK);
        #3 rst_n = 1'b1;
        send(1'b0, 48'h4D_00_00_00_00_0D, 2, 8'h05, 1'b1);
        wait_idle();

`ifdef SD_CMD_ARB_STATS_EN
        // V6: statistics counters
        do_reset();
        send(1'b1, 48'h4D_00_00_00_00_0D, 1, 8'h00, 1'b1);
        send(1'b1, 48'h4D_00_00_00_00_0D, -1, 8'hFF, 1'b1);
        send(1'b1, 48'h4D_00_00_00_00_0D, 0, 8'h04, 1'b1);
        wait_idle();
        chk("stat_cmd1", stat_cmd1, 3);
        chk("stat_tmo", stat_tmo, 1);
        chk("stat_cmd0", stat_cmd0, 0);
`endif

        repeat (5) @(posedge SD_CK);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
